// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-line direct-mapped cache read path.
package cache_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_FILL, S_RESP, S_FLUSH
  } state_t;

  localparam int LINES  = 4;
  localparam int LINE_W = 2;

  // Everything above the line index is tag.
  function automatic int tag_w(input int addr_w);
    return addr_w - LINE_W;
  endfunction
endpackage

// File: rtl/cache_if.sv
// CPU, memory, valid-array and debug-counter signals of the cache controller.
interface cache_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_busy;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              flush;
  logic              flush_done;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [LINE_W-1:0] vld_line;
  logic              vld_wr;
  logic              vld_clr;
  logic              vld_dout;
  logic [7:0]        hit_cnt;
  logic [7:0]        miss_cnt;

  // slave: the controller; master: CPU, memory and valid array around it
  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata, vld_dout,
    output cpu_busy, cpu_ready, cpu_rdata, flush_done, mem_req, mem_addr,
           vld_line, vld_wr, vld_clr, hit_cnt, miss_cnt
  );
  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rdata, vld_dout,
    input  cpu_busy, cpu_ready, cpu_rdata, flush_done, mem_req, mem_addr,
           vld_line, vld_wr, vld_clr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module cache_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cache_ctrl.sv
// Read-path controller: lookup against external valid bits and internal
// tag/data, single-word fill from memory on miss, whole-cache flush.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic  clk,
  input  logic  reset,
  cache_if.slave bus
);
  localparam int TAG_W = tag_w(ADDR_W);

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             addr_q;
  logic [LINES-1:0][TAG_W-1:0]   tag_q;
  logic [LINES-1:0][DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]             rdata_q;
  logic [LINE_W-1:0]             line;
  logic                          hit, hit_inc, miss_inc;

  assign line = addr_q[LINE_W-1:0];
  assign hit  = bus.vld_dout && (tag_q[line] == addr_q[ADDR_W-1:LINE_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        // flush wins; a simultaneous cpu_req is dropped
        if (bus.flush)        state_d = S_FLUSH;
        else if (bus.cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_inc = 1'b1;
          state_d = S_RESP;
        end else begin
          miss_inc = 1'b1;
          state_d  = S_MISS;
        end
      end
      S_MISS:  if (bus.mem_ack) state_d = S_FILL;
      S_FILL:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && !bus.flush && bus.cpu_req)
        addr_q <= bus.cpu_addr;
      if (state_q == S_LOOKUP && hit)
        rdata_q <= data_q[line];
      if (state_q == S_MISS && bus.mem_ack) begin
        data_q[line] <= bus.mem_rdata;
        tag_q[line]  <= addr_q[ADDR_W-1:LINE_W];
        rdata_q      <= bus.mem_rdata;
      end
    end
  end

  // Outputs come only from registers or the state register.
  assign bus.cpu_busy   = (state_q != S_IDLE);
  assign bus.cpu_ready  = (state_q == S_RESP);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.mem_req    = (state_q == S_MISS);
  assign bus.mem_addr   = addr_q;
  assign bus.vld_line   = line;
  assign bus.vld_wr     = (state_q == S_FILL);
  assign bus.vld_clr    = (state_q == S_FLUSH);
  assign bus.flush_done = (state_q == S_FLUSH);

  cache_sat_counter #(.W(8)) u_hit_cnt (
    .clk(clk), .reset(reset), .inc(hit_inc), .cnt(bus.hit_cnt)
  );
  cache_sat_counter #(.W(8)) u_miss_cnt (
    .clk(clk), .reset(reset), .inc(miss_inc), .cnt(bus.miss_cnt)
  );
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: vector table of reads plus flush, reset-mid-miss
// and counter saturation sequences; returned words checked via a scoreboard.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   hits_exp = 0;
  int   misses_exp = 0;
  logic [3:0] valid_q;

  typedef struct {
    logic [7:0] addr;
    int         dly;
    logic [7:0] mdata;
    bit         hit;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  cache_if #(.ADDR_W(8), .DATA_W(8)) ifc ();

  cache_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External valid-bit array, sharing the controller's reset.
  always @(posedge clk or posedge reset) begin
    if (reset)            valid_q <= '0;
    else if (ifc.vld_clr) valid_q <= '0;
    else if (ifc.vld_wr)  valid_q[ifc.vld_line] <= 1'b1;
  end
  assign ifc.vld_dout = valid_q[ifc.vld_line];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Issue one read at the current negedge and act as memory if it misses.
  task automatic do_read(input logic [7:0] a, input int d, input logic [7:0] md,
                         input bit h, input logic [7:0] rd);
    int t0;
    int n;
    exp_t e;
    logic [1:0] ln;
    ln = a[1:0];
    t0 = cyc;
    ifc.cpu_req  = 1'b1;
    ifc.cpu_addr = a;
    e.rdata = rd;
    e.cyc   = h ? t0 + 2 : t0 + 4 + d;
    sb.push_back(e);
    if (h) hits_exp++; else misses_exp++;
    @(negedge clk);
    ifc.cpu_req = 1'b0;
    @(negedge clk);
    chk("mem_req", 32'(ifc.mem_req), 32'(!h));
    if (!h) begin
      for (int i = 0; i < d; i++) begin
        chk("mem_addr_hold", 32'(ifc.mem_addr), 32'(a));
        @(negedge clk);
        chk("mem_req_hold", 32'(ifc.mem_req), 32'd1);
      end
      chk("mem_addr", 32'(ifc.mem_addr), 32'(a));
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = md;
      @(negedge clk);
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = 8'h00;
      chk("vld_wr", 32'(ifc.vld_wr), 32'd1);
      chk("vld_line", 32'(ifc.vld_line), 32'(ln));
    end
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no cpu_ready expected one for addr %0h", a);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h15, 0, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'h15, 0, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{8'h25, 1, 8'h3C, 1'b0, 8'h3C};
    vecs[3] = '{8'h15, 0, 8'hA5, 1'b0, 8'hA5};
    vecs[4] = '{8'h02, 2, 8'h77, 1'b0, 8'h77};
    vecs[5] = '{8'h02, 0, 8'h00, 1'b1, 8'h77};
    vecs[6] = '{8'h25, 0, 8'h3C, 1'b0, 8'h3C};
    vecs[7] = '{8'h25, 0, 8'h00, 1'b1, 8'h3C};
    vecs[8] = '{8'h02, 0, 8'h00, 1'b1, 8'h77};

    ifc.cpu_req = 1'b0; ifc.cpu_addr = 8'h00; ifc.flush = 1'b0;
    ifc.mem_ack = 1'b0; ifc.mem_rdata = 8'h00;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (ifc.cpu_ready === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: got cpu_ready=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("cpu_rdata", 32'(ifc.cpu_rdata), 32'(e.rdata));
            chk("ready_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(ifc.cpu_busy), 32'd0);
    chk("rst_rdata", 32'(ifc.cpu_rdata), 32'd0);
    chk("rst_mem", 32'({ifc.mem_req, ifc.mem_addr}), 32'd0);
    chk("rst_vld", 32'({ifc.vld_wr, ifc.vld_clr, ifc.flush_done, ifc.vld_line}), 32'd0);
    chk("rst_cnt", 32'({ifc.hit_cnt, ifc.miss_cnt}), 32'd0);

    for (int i = 0; i < 9; i++)
      do_read(vecs[i].addr, vecs[i].dly, vecs[i].mdata, vecs[i].hit, vecs[i].rdata);
    chk("hit_cnt_tab", 32'(ifc.hit_cnt), 32'(sat(hits_exp)));
    chk("miss_cnt_tab", 32'(ifc.miss_cnt), 32'(sat(misses_exp)));

    // Flush with a simultaneous read: the read is dropped.
    ifc.flush = 1'b1; ifc.cpu_req = 1'b1; ifc.cpu_addr = 8'h25;
    @(negedge clk);
    ifc.flush = 1'b0; ifc.cpu_req = 1'b0;
    chk("flush_vld_clr", 32'(ifc.vld_clr), 32'd1);
    chk("flush_done", 32'(ifc.flush_done), 32'd1);
    @(negedge clk);
    chk("flush_idle", 32'({ifc.cpu_busy, ifc.flush_done, ifc.vld_clr}), 32'd0);
    do_read(8'h25, 3, 8'h3C, 1'b0, 8'h3C);
    chk("hit_cnt_flush", 32'(ifc.hit_cnt), 32'(sat(hits_exp)));
    chk("miss_cnt_flush", 32'(ifc.miss_cnt), 32'(sat(misses_exp)));

    // Withheld ack, then reset in the middle of the miss.
    ifc.cpu_req = 1'b1; ifc.cpu_addr = 8'h33;
    @(negedge clk);
    ifc.cpu_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("dly_mem_req", 32'(ifc.mem_req), 32'd1);
      chk("dly_mem_addr", 32'(ifc.mem_addr), 32'h33);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(ifc.mem_req), 32'd0);
    chk("rst_mid_busy", 32'(ifc.cpu_busy), 32'd0);
    chk("rst_mid_cnt", 32'({ifc.hit_cnt, ifc.miss_cnt}), 32'd0);
    hits_exp = 0; misses_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 8'hEE;
    @(negedge clk);
    ifc.mem_ack = 1'b0;
    chk("late_ack_ignored", 32'({ifc.cpu_busy, ifc.vld_wr, ifc.cpu_rdata}), 32'd0);
    @(negedge clk);

    // Hit counter saturation on one line.
    do_read(8'h15, 0, 8'h5A, 1'b0, 8'h5A);
    for (int i = 0; i < 254; i++) do_read(8'h15, 0, 8'h00, 1'b1, 8'h5A);
    chk("hit_cnt_fe", 32'(ifc.hit_cnt), 32'hFE);
    for (int i = 0; i < 46; i++) do_read(8'h15, 0, 8'h00, 1'b1, 8'h5A);
    chk("hit_cnt_sat", 32'(ifc.hit_cnt), 32'(sat(hits_exp)));
    chk("miss_cnt_sat", 32'(ifc.miss_cnt), 32'(sat(misses_exp)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Read-path controller for the 4-line direct-mapped cache. It accepts one CPU read at a time, looks up the external valid-bit array and internal tag/data storage, and on a miss fetches the word from memory through a request/acknowledge handshake. It then fills the line, sets its valid bit and returns the data. It also sequences a whole-cache flush and keeps saturating hit/miss counters for debug.

## Interface
Parameters:
- ADDR_W, 8, CPU/memory word-address width; line index = addr[1:0], tag = addr[ADDR_W-1:2]
- DATA_W, 8, data word width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  read request, sampled only when cpu_busy=0
- cpu_addr  in  ADDR_W  request address, sampled with cpu_req
- cpu_busy  out  1  high whenever state≠IDLE
- cpu_ready  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  returned word, held until next cpu_ready
- flush  in  1  flush request, sampled only in IDLE
- flush_done  out  1  one-cycle pulse at end of flush
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  ADDR_W  memory address, stable while mem_req=1
- mem_ack  in  1  memory acknowledge; mem_rdata valid same cycle
- mem_rdata  in  DATA_W  memory read data
- vld_line  out  2  line index to valid array (captured address bits [1:0])
- vld_wr  out  1  set valid bit of vld_line (one cycle)
- vld_clr  out  1  clear all valid bits (one cycle)
- vld_dout  in  1  valid bit of vld_line, combinational
- hit_cnt  out  8  saturating hit count
- miss_cnt  out  8  saturating miss count

## Operation
- States: IDLE, LOOKUP, MISS, FILL, RESP, FLUSH.
- IDLE:
  - flush=1 → FLUSH (flush has priority over cpu_req; cpu_req that cycle is dropped).
  - Else cpu_req=1 → capture cpu_addr into addr_q → LOOKUP.
- LOOKUP:
  - vld_line=addr_q[1:0].
  - Hit = vld_dout && tag[line]==addr_q[ADDR_W-1:2].
  - Hit: load cpu_rdata from data[line], hit_cnt+1, → RESP.
  - Miss: miss_cnt+1, → MISS.
- MISS:
  - mem_req=1, mem_addr=addr_q.
  - On mem_ack: write data[line]=mem_rdata, tag[line]=addr_q tag, cpu_rdata=mem_rdata → FILL.
- FILL: vld_wr=1 for one cycle → RESP.
- RESP: cpu_ready=1 for one cycle → IDLE.
- FLUSH: vld_clr=1 and flush_done=1 for one cycle → IDLE. Tags and data are untouched.
- Counters saturate at 8'hFF; no wrap.
- mem_ack outside MISS is ignored.
- cpu_req/flush while busy are ignored; requesters must hold or retry.
- Reset values:
  - State IDLE; all outputs 0, including cpu_rdata, hit_cnt, miss_cnt.
  - Tag/data arrays cleared.
  - Valid array is cleared by the shared reset.
- Reset mid-MISS: mem_req drops asynchronously; any later mem_ack is ignored.

## Timing
- Hit: cpu_req in cycle 0, LOOKUP cycle 1, cpu_ready in cycle 2 (latency 2).
- Miss: cpu_ready 2 cycles after the mem_ack cycle. With mem_ack in the first MISS cycle (cycle 2), cpu_ready comes in cycle 4.
- Flush: flush in cycle 0, vld_clr/flush_done in cycle 1, accepts a new request in cycle 2.
- Back-to-back: next cpu_req is accepted the cycle after cpu_ready.
- All outputs registered or decoded from state register only. No combinational path from cpu_req/mem_ack to outputs.

## Structure
- Shared package cache_pkg:
  - State enum (3-bit encoding).
  - LINES=4, LINE_W=2 constants.
  - Tag-width helper: TAG_W = ADDR_W-2.
- Natural sub-module: cache_sat_counter (8-bit saturating incrementer with reset), instantiated twice.
- Valid array stays external; tag/data storage is internal to cache_ctrl.

## Test plan
- Cold miss: reset, cpu_req addr=8'h15, mem_ack with mem_rdata=8'hA5 on first MISS cycle.
  - mem_addr=8'h15.
  - vld_wr with vld_line=1.
  - cpu_ready with cpu_rdata=8'hA5 at cycle 4.
  - miss_cnt=1.
- Hit after fill: repeat addr=8'h15 → cpu_ready at cycle 2, rdata=8'hA5, no mem_req, hit_cnt=1.
- Conflict miss: addr=8'h25 (same line 1, tag differs), memory returns 8'h3C.
  - mem_req issued; rdata=8'h3C.
  - Then addr=8'h15 misses again.
- Flush: flush=1 and cpu_req=1 together in IDLE.
  - vld_clr and flush_done pulse next cycle; request dropped.
  - Subsequent addr=8'h25 misses.
- Delayed ack and reset: mem_ack withheld 5 cycles → mem_req/mem_addr stable throughout. Assert reset mid-MISS → mem_req=0 immediately, state IDLE, counters 0.
- Saturation: 300 hits to one line → hit_cnt=8'hFF, no wrap.
